conv_uart_tx: RTL

//   Transmit side of the convolution UART link. Accepts result bytes from the

---
 rtl/uart_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 70 +++++++
 rtl/conv_uart_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (TX state encoding and line levels).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous show-ahead FIFO; read data valid whenever !empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
    parameter int D_BITS     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [D_BITS-1:0] i_wdata,
    input  logic              i_pop,
    output logic [D_BITS-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(FIFO_DEPTH);

    logic [D_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rptr];

    // A push into a full FIFO is only taken when a pop frees the slot this cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_uart_tx.sv
// ============================================================================
//  Module      : conv_uart_tx
//  Description : Buffered 8N1 UART transmitter for convolution result bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_uart_tx #(
    parameter int D_BITS       = 8,
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_dvalid,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_overflow
);

    import uart_pkg::*;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(D_BITS);
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] C_BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(D_BITS - 1);
    localparam logic [BIT_W-1:0]  C_BIT_ONE   = BIT_W'(1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [BIT_W-1:0]  r_bit;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [D_BITS-1:0] r_shift;
    logic [D_BITS-1:0] w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_busy;
    logic              r_overflow;

    logic              w_baud_done;
    logic              w_pop;
    logic              w_push;
    logic [D_BITS-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign w_push = i_dvalid && (!w_fifo_full || w_pop);

    byte_fifo #(
        .D_BITS     (D_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (i_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_baud_done = (r_baud == C_BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_done ? '0 : r_baud + C_BAUD_ONE;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt   = UART_IDLE_LVL;
                w_baud_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_tx_nxt    = UART_START_LVL;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    if (r_bit == C_BIT_LAST) begin
                        w_tx_nxt    = UART_IDLE_LVL;
                        w_state_nxt = STOP;
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                        w_bit_nxt   = r_bit + C_BIT_ONE;
                    end
                end
            end
            STOP: begin
                // Back-to-back frames: the next start bit begins on the stop-bit expiry edge.
                if (w_baud_done) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_tx_nxt    = UART_START_LVL;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = UART_IDLE_LVL;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= UART_IDLE_LVL;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            // Busy tracks the post-edge state and FIFO occupancy.
            r_busy  <= (w_state_nxt != IDLE) || !w_fifo_empty || w_push;
            if (i_dvalid && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_full     = w_fifo_full;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire
